muldiv32: RTL and testbench

Iterative multiply/divide unit downstream of the 32-entry register file. It consumes the two register read ports (rs on ReadData1, rt on ReadData2) when the decode stage issues a MULT/MULTU/DIV/DIVU. It computes the 64-bit product or the quotient/remainder over WIDTH+1 cycles and holds the result in architectural HI/LO registers. The pipeline reads HI/LO and stalls on `busy`.

---
 rtl/muldiv32.sv | 155 +++++++++++++++
 tb/tb_muldiv32.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/muldiv32.sv
// Iterative MULT/MULTU/DIV/DIVU unit. The result lands in HI/LO WIDTH+1 edges after accept.
// No backpressure: start is taken only in IDLE and dropped otherwise; busy flags the stall window.
module muldiv32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] ReadData1,
    input  logic [WIDTH-1:0] ReadData2,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t               state_q, state_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_lo_q, neg_lo_d;
    logic                 neg_hi_q, neg_hi_d;
    logic                 dbz_q, dbz_d;
    logic [WIDTH-1:0]     mag_b_q, mag_b_d;
    logic [WIDTH-1:0]     raw_a_q, raw_a_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 busy_q, busy_d, done_q, done_d, dbz_out_q, dbz_out_d;

    logic                 a_neg, b_neg;
    logic [WIDTH:0]       mul_sum, rem_sh, rem_new;
    logic                 rem_ge;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod;
    logic [WIDTH-1:0]     quo, rem;

    always_comb begin
        a_neg    = ~op[0] & ReadData1[WIDTH-1];
        b_neg    = ~op[0] & ReadData2[WIDTH-1];

        // Multiply: LO half starts as the multiplier and is shifted out as the product shifts in.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_ge   = rem_sh >= {1'b0, mag_b_q};
        rem_new  = rem_ge ? (rem_sh - {1'b0, mag_b_q}) : rem_sh;
        div_next = {rem_new[WIDTH-1:0], acc_q[WIDTH-2:0], rem_ge};

        prod     = neg_lo_q ? -acc_q : acc_q;
        quo      = acc_q[WIDTH-1:0];
        rem      = acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        is_div_d  = is_div_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        dbz_d     = dbz_q;
        mag_b_d   = mag_b_q;
        raw_a_d   = raw_a_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dbz_out_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    is_div_d = op[1];
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = a_neg;
                    dbz_d    = op[1] & (ReadData2 == '0);
                    raw_a_d  = ReadData1;
                    mag_b_d  = b_neg ? -ReadData2 : ReadData2;
                    acc_d    = {{WIDTH{1'b0}}, (a_neg ? -ReadData1 : ReadData1)};
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                    cnt_d   = '0;
                end
            end
            S_FIX: begin
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                dbz_out_d = dbz_q;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod;
                end else if (dbz_q) begin
                    hi_d = raw_a_q;
                    lo_d = '1;
                end else begin
                    hi_d = neg_hi_q ? -rem : rem;
                    lo_d = neg_lo_q ? -quo : quo;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            is_div_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            dbz_q     <= 1'b0;
            mag_b_q   <= '0;
            raw_a_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_div_q  <= is_div_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
            dbz_q     <= dbz_d;
            mag_b_q   <= mag_b_d;
            raw_a_q   <= raw_a_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_out_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_muldiv32.sv
// Directed bench for muldiv32: expected results are queued at issue and checked by a monitor on done.
module tb_muldiv32;
    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] ReadData1, ReadData2;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    muldiv32 #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           acc;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL spurious_done: got done=1 at cycle %0d, required no pulse", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, ".hi"}, 64'(hi), 64'(e.hi));
                    chk({e.name, ".lo"}, 64'(lo), 64'(e.lo));
                    chk({e.name, ".dbz"}, 64'(div_by_zero), 64'(e.dbz));
                    chk({e.name, ".latency"}, 64'(cyc - e.acc), 64'(LAT));
                    chk({e.name, ".busy_at_done"}, 64'(busy), 64'd0);
                end
            end else if (div_by_zero) begin
                n_cmp++;
                n_mis++;
                $display("FAIL dbz_without_done: got div_by_zero=1 at cycle %0d, required 0", cyc);
            end
        end
    end

    // Waits for IDLE (busy low) at a falling edge, presents the op for one edge.
    task automatic issue(input string nm, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eh,
                         input logic [W-1:0] el, input logic ed, input bit push);
        exp_t e;
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        if (busy) begin
            n_cmp++;
            n_mis++;
            $display("FAIL %s.idle_timeout: busy still 1 after %0d cycles, required 0", nm, n);
        end
        start     = 1'b1;
        op        = o;
        ReadData1 = a;
        ReadData2 = b;
        if (push) begin
            e.hi = eh; e.lo = el; e.dbz = ed; e.acc = cyc + 1; e.name = nm;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start     = 1'b0;
        ReadData1 = 32'hDEAD_BEEF;
        ReadData2 = 32'h0BAD_F00D;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 2'b00; ReadData1 = '0; ReadData2 = '0;
        repeat (3) @(negedge clk);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.dbz", 64'(div_by_zero), 64'd0);
        chk("rst.hi", 64'(hi), 64'd0);
        chk("rst.lo", 64'(lo), 64'd0);
        reset = 1'b1;

        issue("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1);
        chk("multu_max.busy_e0", 64'(busy), 64'd1);
        repeat (W) @(negedge clk);
        chk("multu_max.busy_e32", 64'(busy), 64'd1);
        chk("multu_max.done_e32", 64'(done), 64'd0);

        issue("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1);
        issue("mult_min_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 1);
        issue("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1);
        issue("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1);
        issue("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1);
        issue("div_7_neg2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 1);
        issue("divu_by0", 2'b11, 32'h64, 32'h0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1);
        issue("div_neg_by0", 2'b10, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 1);
        issue("multu_shift", 2'b01, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, 1'b0, 1);

        // Noise on start and operands while busy must not disturb or requeue the op.
        issue("multu_5x6", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 1);
        for (int i = 0; i < 20; i++) begin
            start     = ~start;
            op        = 2'($urandom_range(0, 3));
            ReadData1 = $urandom;
            ReadData2 = $urandom;
            @(negedge clk);
        end
        start = 1'b0;

        // Abort a divide at RUN edge 10.
        issue("divu_abort", 2'b11, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 0);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.done", 64'(done), 64'd0);
        chk("abort.dbz", 64'(div_by_zero), 64'd0);
        chk("abort.hi", 64'(hi), 64'd0);
        chk("abort.lo", 64'(lo), 64'd0);
        reset = 1'b1;

        issue("divu_9_3", 2'b11, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 1);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("outstanding_results", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
